// File: rtl/fpu_dest_tracker_if.sv
// Bundle between the FPU issue/decode logic and the destination-tag tracker.
// master: issue/decode side driving ops and source tags.
// slave : the tracker, which returns ready/hazard, forwarding tags and writeback.
interface fpu_dest_tracker_if #(
    parameter int REG_W = 5
);
    logic             stall;
    logic             flush;
    logic             issue_valid;
    logic [REG_W-1:0] issue_rd;
    logic [1:0]       issue_lat;
    logic             issue_ready;
    logic [REG_W-1:0] rsia;
    logic [REG_W-1:0] rsib;
    logic             raw_hazard;
    logic [REG_W-1:0] rdi_buf_1;
    logic [REG_W-1:0] rdi_buf_2;
    logic [REG_W-1:0] rdi_buf_3;
    logic [REG_W-1:0] rdi_buf_4;
    logic             legal_1;
    logic             legal_2;
    logic             legal_3;
    logic             legal_4;
    logic             wb_en;
    logic [REG_W-1:0] wb_rd;

    modport master (
        output stall, flush, issue_valid, issue_rd, issue_lat, rsia, rsib,
        input  issue_ready, raw_hazard,
        input  rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4,
        input  legal_1, legal_2, legal_3, legal_4,
        input  wb_en, wb_rd
    );

    modport slave (
        input  stall, flush, issue_valid, issue_rd, issue_lat, rsia, rsib,
        output issue_ready, raw_hazard,
        output rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4,
        output legal_1, legal_2, legal_3, legal_4,
        output wb_en, wb_rd
    );
endinterface

// File: rtl/fpu_dest_tracker.sv
// Destination-tag tracker for a fixed 4-stage FPU result pipeline.
// Each stage holds {valid, rd, cnt}; an entry is forwardable once cnt reaches 0.
// Produces forwarding tags, RAW hazard for decode and the register-file write port.
// Optional macro FPU_WAW_CHECK_EN: refuse issue while an unfinished entry targets
// the same destination, so results can never overwrite each other out of order.
module fpu_dest_tracker #(
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    fpu_dest_tracker_if.slave   bus
);
    // Index 0 is stage 1 (youngest), index 3 is stage 4 (retiring).
    logic [3:0]       v_q, v_d;
    logic [REG_W-1:0] rd_q  [4];
    logic [REG_W-1:0] rd_d  [4];
    logic [1:0]       cnt_q [4];
    logic [1:0]       cnt_d [4];

    // kill_mask[n] is set when 1-based stage n is cleared by a flush; bit 0 is the issue slot.
    logic [4:0]       kill_mask;
    logic             shift;
    logic             accept;
    logic             waw_block;
    logic             haz_a, haz_b;

    function automatic logic [1:0] dec_sat(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    assign kill_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi <= 4; gi++) begin : g_kill
            assign kill_mask[gi] = (gi <= FLUSH_DEPTH);
        end
    endgenerate

    assign shift  = ~bus.stall;
    assign accept = bus.issue_valid & bus.issue_ready;

`ifdef FPU_WAW_CHECK_EN
    // Block issue while any unfinished entry will still write the same register.
    always_comb begin
        waw_block = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (v_q[k] && (cnt_q[k] != 2'd0) && (rd_q[k] == bus.issue_rd)) begin
                waw_block = 1'b1;
            end
        end
    end
`else
    assign waw_block = 1'b0;
`endif

    assign bus.issue_ready = ~bus.stall & ~bus.flush & ~waw_block;

    // Next state: hold or shift, countdown always runs, flush clears the young stages.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            v_d[k]   = v_q[k] & ~(bus.flush & kill_mask[k+1]);
            rd_d[k]  = rd_q[k];
            cnt_d[k] = dec_sat(cnt_q[k]);
        end
        if (shift) begin
            v_d[0]   = accept;
            rd_d[0]  = bus.issue_rd;
            cnt_d[0] = bus.issue_lat;
            for (int k = 1; k < 4; k++) begin
                v_d[k]   = v_q[k-1] & ~(bus.flush & kill_mask[k]);
                rd_d[k]  = rd_q[k-1];
                cnt_d[k] = dec_sat(cnt_q[k-1]);
            end
        end
        // Invalid slots are kept at zero so the tag outputs stay clean.
        for (int k = 0; k < 4; k++) begin
            if (!v_d[k]) begin
                rd_d[k]  = '0;
                cnt_d[k] = 2'd0;
            end
        end
    end

    // Stage registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                rd_q[k]  <= '0;
                cnt_q[k] <= 2'd0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < 4; k++) begin
                rd_q[k]  <= rd_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Youngest valid match per source decides; a ready young match shadows older ones.
    always_comb begin
        logic found_a, found_b;
        found_a = 1'b0;
        found_b = 1'b0;
        haz_a   = 1'b0;
        haz_b   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found_a && v_q[k] && (rd_q[k] == bus.rsia)) begin
                found_a = 1'b1;
                haz_a   = (cnt_q[k] != 2'd0);
            end
            if (!found_b && v_q[k] && (rd_q[k] == bus.rsib)) begin
                found_b = 1'b1;
                haz_b   = (cnt_q[k] != 2'd0);
            end
        end
    end

    assign bus.raw_hazard = haz_a | haz_b;

    assign bus.rdi_buf_1 = rd_q[0];
    assign bus.rdi_buf_2 = rd_q[1];
    assign bus.rdi_buf_3 = rd_q[2];
    assign bus.rdi_buf_4 = rd_q[3];
    assign bus.legal_1   = v_q[0] & (cnt_q[0] == 2'd0);
    assign bus.legal_2   = v_q[1] & (cnt_q[1] == 2'd0);
    assign bus.legal_3   = v_q[2] & (cnt_q[2] == 2'd0);
    assign bus.legal_4   = v_q[3] & (cnt_q[3] == 2'd0);
    assign bus.wb_en     = v_q[3] & ~bus.stall;
    assign bus.wb_rd     = rd_q[3];
endmodule

// File: tb/tb_fpu_dest_tracker.sv
// Directed bench for fpu_dest_tracker (FLUSH_DEPTH=2). Writebacks are predicted
// at issue time into a scoreboard queue (register and cycle of retirement);
// a negedge monitor pops and compares every writeback the DUT presents.
module tb_fpu_dest_tracker;
    localparam int REG_W = 5;
`ifdef FPU_WAW_CHECK_EN
    localparam int WAW_READY_EXP = 0;
`else
    localparam int WAW_READY_EXP = 1;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fpu_dest_tracker_if #(.REG_W(REG_W)) bus ();

    fpu_dest_tracker #(.REG_W(REG_W), .FLUSH_DEPTH(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [REG_W-1:0] rd;
        int               cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; predict its writeback cycle if it is meant to retire.
    task automatic issue_op(input logic [REG_W-1:0] rd, input logic [1:0] lat,
                            input bit retire, input int delay);
        exp_t e;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        bus.issue_lat   = lat;
        #1;
        check("issue_ready_on_issue", int'(bus.issue_ready), 1);
        if (retire) begin
            e.rd  = rd;
            e.cyc = cyc + 4 + delay;
            exp_q.push_back(e);
        end
        $display("issue rd=%0d lat=%0d cycle=%0d retire=%0d", rd, lat, cyc, retire);
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_lat   = 2'd0;
    endtask

    // Scoreboard monitor: every presented writeback must match the oldest prediction.
    always @(negedge clk) begin
        if (bus.wb_en) begin
            exp_t e;
            int   n;
            n = exp_q.size();
            check("wb_expected", int'(n > 0), 1);
            if (n > 0) begin
                e = exp_q.pop_front();
                check("wb_rd", int'(bus.wb_rd), int'(e.rd));
                check("wb_cycle", cyc, e.cyc);
                $display("writeback rd=%0d cycle=%0d (predicted rd=%0d cycle=%0d)",
                         bus.wb_rd, cyc, e.rd, e.cyc);
            end
        end
    end

    initial begin
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_lat   = 2'd0;
        bus.rsia        = '0;
        bus.rsib        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_legal", int'({bus.legal_1, bus.legal_2, bus.legal_3, bus.legal_4}), 0);
        check("rst_rdi_buf", int'(bus.rdi_buf_1 | bus.rdi_buf_2 | bus.rdi_buf_3 | bus.rdi_buf_4), 0);
        check("rst_wb_en", int'(bus.wb_en), 0);
        check("rst_raw_hazard", int'(bus.raw_hazard), 0);
        check("rst_issue_ready", int'(bus.issue_ready), 1);
        rstn = 1'b1;
        tick();

        // 1: lat=0 op is forwardable in s1 and retires 3 cycles later
        issue_op(5'd5, 2'd0, 1'b1, 0);
        check("t1_rdi_buf_1", int'(bus.rdi_buf_1), 5);
        check("t1_legal_1", int'(bus.legal_1), 1);
        repeat (4) tick();

        // 2: lat=3 op is not forwardable until s4; hazard in s2, none in s4
        issue_op(5'd7, 2'd3, 1'b1, 0);
        check("t2_legal_1", int'(bus.legal_1), 0);
        tick();
        bus.rsia = 5'd7;
        #1;
        check("t2_hazard_s2", int'(bus.raw_hazard), 1);
        check("t2_legal_2", int'(bus.legal_2), 0);
        tick();
        check("t2_legal_3", int'(bus.legal_3), 0);
        tick();
        check("t2_legal_4", int'(bus.legal_4), 1);
        check("t2_rdi_buf_4", int'(bus.rdi_buf_4), 7);
        check("t2_hazard_s4", int'(bus.raw_hazard), 0);
        bus.rsia = '0;
        repeat (2) tick();

`ifndef FPU_WAW_CHECK_EN
        // 3: ready younger match shadows an unready older one
        issue_op(5'd9, 2'd3, 1'b1, 0);
        issue_op(5'd9, 2'd0, 1'b1, 0);
        bus.rsib = 5'd9;
        #1;
        check("t3_shadow_hazard", int'(bus.raw_hazard), 0);
        check("t3_legal_1", int'(bus.legal_1), 1);
        check("t3_legal_2", int'(bus.legal_2), 0);
        bus.rsib = '0;
        repeat (5) tick();
`endif

        // 4: countdown continues during stall; writeback pushed out by the stall
        issue_op(5'd3, 2'd3, 1'b1, 3);
        bus.stall = 1'b1;
        #1;
        check("t4_issue_ready_stall", int'(bus.issue_ready), 0);
        repeat (3) tick();
        check("t4_legal_1_stalled", int'(bus.legal_1), 1);
        check("t4_rdi_buf_1", int'(bus.rdi_buf_1), 3);
        check("t4_wb_en_stall", int'(bus.wb_en), 0);
        bus.stall = 1'b0;
        repeat (4) tick();

        // 4b: stall while an entry sits in s4 suppresses writeback
        issue_op(5'd11, 2'd0, 1'b1, 2);
        repeat (3) tick();
        bus.stall = 1'b1;
        #1;
        check("t4b_wb_en_stall_s4", int'(bus.wb_en), 0);
        check("t4b_legal_4", int'(bus.legal_4), 1);
        repeat (2) tick();
        bus.stall = 1'b0;
        repeat (2) tick();

        // 5: flush kills s1/s2, s3 moves to s4, s4 retires
        issue_op(5'd4, 2'd0, 1'b1, 0);
        issue_op(5'd3, 2'd0, 1'b1, 0);
        issue_op(5'd2, 2'd0, 1'b0, 0);
        issue_op(5'd1, 2'd0, 1'b0, 0);
        check("t5_rdi_buf_1", int'(bus.rdi_buf_1), 1);
        check("t5_rdi_buf_3", int'(bus.rdi_buf_3), 3);
        bus.flush = 1'b1;
        #1;
        check("t5_issue_ready_flush", int'(bus.issue_ready), 0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("t5_legal_123", int'({bus.legal_1, bus.legal_2, bus.legal_3}), 0);
        check("t5_legal_4", int'(bus.legal_4), 1);
        check("t5_rdi_buf_4", int'(bus.rdi_buf_4), 3);
        repeat (2) tick();

        // 5b: flush during stall kills s1/s2, s3 holds
        issue_op(5'd12, 2'd0, 1'b1, 1);
        issue_op(5'd13, 2'd0, 1'b0, 0);
        issue_op(5'd14, 2'd0, 1'b0, 0);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check("t5b_legal_12", int'({bus.legal_1, bus.legal_2}), 0);
        check("t5b_legal_3", int'(bus.legal_3), 1);
        check("t5b_rdi_buf_3", int'(bus.rdi_buf_3), 12);
        bus.stall = 1'b0;
        repeat (3) tick();

        // WAW: pending unready rd=6 vs a new rd=6 at the issue port
        issue_op(5'd6, 2'd3, 1'b1, 0);
        bus.issue_rd = 5'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("waw_issue_ready_pending", int'(bus.issue_ready), WAW_READY_EXP);
            tick();
        end
        check("waw_issue_ready_done", int'(bus.issue_ready), 1);
        bus.issue_rd = '0;
        repeat (2) tick();

        // 6: reset with a full pipe clears everything at once, no writebacks follow
        issue_op(5'd20, 2'd0, 1'b0, 0);
        issue_op(5'd21, 2'd0, 1'b0, 0);
        issue_op(5'd22, 2'd0, 1'b0, 0);
        issue_op(5'd23, 2'd0, 1'b0, 0);
        rstn = 1'b0;
        #1;
        check("t6_legal_async", int'({bus.legal_1, bus.legal_2, bus.legal_3, bus.legal_4}), 0);
        check("t6_wb_en_async", int'(bus.wb_en), 0);
        check("t6_rdi_buf_4", int'(bus.rdi_buf_4), 0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        check("t6_legal_after", int'({bus.legal_1, bus.legal_2, bus.legal_3, bus.legal_4}), 0);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
